// File: rtl/fetch_halt_pkg.sv
// Shared types and constants for the fetch/halt controller.
//   state_t         : controller FSM states
//   OP_W            : opcode field width; the field sits in the top OP_W bits
//                     of the instruction word
//   HALT_OP_DEFAULT : default opcode that stops execution
package fetch_halt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PAUSE,
        ST_HALTED
    } state_t;

    localparam int unsigned      OP_W            = 6;
    localparam logic [OP_W-1:0]  HALT_OP_DEFAULT = 6'h3F;

endpackage

// File: rtl/fetch_halt_ctrl_if.sv
// Instruction-memory fetch bus.
//   imem_addr  : fetch address (controller -> memory)
//   imem_rdata : fetched instruction word (memory -> controller)
//   imem_valid : imem_rdata is valid this cycle (memory -> controller)
// master = controller side, slave = memory side.
interface fetch_halt_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_valid;

    modport master (output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_pc.sv
// Program counter register.
//   clk, rst : clock, synchronous active-high reset (pc -> 0)
//   clr      : load zero
//   inc      : advance by one, wrapping modulo 2^ADDR_W
//   pc       : current program counter
module fetch_pc #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_halt_ctrl.sv
// Fetch / retire / halt controller.
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse, begin fetching from pc (IDLE only)
//   step_mode    : pause after each retired instruction
//   step         : pulse, release one instruction while paused
//   resume       : pulse, leave HALTED (pc cleared)
//   imem         : fetch bus (addr out, rdata/valid in)
//   pc           : program counter
//   instr        : last retired instruction
//   instr_valid  : one-cycle pulse per retired instruction
//   halted       : high while halted
//   halt_pc      : address of halt word or timed-out fetch
//   timeout_err  : halt was caused by fetch timeout (cleared by resume)
//   retired      : saturating retired-instruction count
module fetch_halt_ctrl
    import fetch_halt_pkg::*;
#(
    parameter int unsigned     DATA_W  = 32,
    parameter int unsigned     ADDR_W  = 8,
    parameter logic [OP_W-1:0] HALT_OP = HALT_OP_DEFAULT,
    parameter int unsigned     TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               resume,
    fetch_halt_ctrl_if.master  imem,
    output logic [ADDR_W-1:0]  pc,
    output logic [DATA_W-1:0]  instr,
    output logic               instr_valid,
    output logic               halted,
    output logic [ADDR_W-1:0]  halt_pc,
    output logic               timeout_err,
    output logic [31:0]        retired
);

    localparam int unsigned         TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]  halt_pc_q, halt_pc_d;
    logic               timeout_err_q, timeout_err_d;
    logic [31:0]        retired_q, retired_d;

    logic               is_halt_op;
    logic               retire;
    logic               halt_hit;
    logic               timeout_hit;
    logic               pc_clr;

    assign is_halt_op = (imem.imem_rdata[DATA_W-1 -: OP_W] == HALT_OP);

    fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk (clk),
        .rst (rst),
        .clr (pc_clr),
        .inc (retire),
        .pc  (pc)
    );

    assign imem.imem_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (halt_hit || timeout_hit) begin
                    state_d = ST_HALTED;
                end else if (retire && step_mode) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE:  if (step || !step_mode) state_d = ST_FETCH;
            ST_HALTED: if (resume) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs / per-cycle control decode
    always_comb begin
        retire      = (state_q == ST_FETCH) && imem.imem_valid && !is_halt_op;
        halt_hit    = (state_q == ST_FETCH) && imem.imem_valid && is_halt_op;
        timeout_hit = (state_q == ST_FETCH) && !imem.imem_valid && (tcnt_q == TCNT_LAST);
        pc_clr      = (state_q == ST_HALTED) && resume;
        halted      = (state_q == ST_HALTED);
    end

    // Datapath next values
    always_comb begin
        // Counter stays at zero outside FETCH so every FETCH entry starts fresh.
        tcnt_d = '0;
        if ((state_q == ST_FETCH) && !imem.imem_valid && !timeout_hit) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        instr_d       = retire ? imem.imem_rdata : instr_q;
        instr_valid_d = retire;
        halt_pc_d     = (halt_hit || timeout_hit) ? pc : halt_pc_q;

        timeout_err_d = timeout_err_q;
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end else if (pc_clr) begin
            timeout_err_d = 1'b0;
        end

        retired_d = retired_q;
        if (retire && (retired_q != '1)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q        <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halt_pc_q     <= '0;
            timeout_err_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            tcnt_q        <= tcnt_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halt_pc_q     <= halt_pc_d;
            timeout_err_q <= timeout_err_d;
            retired_q     <= retired_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halt_pc     = halt_pc_q;
    assign timeout_err = timeout_err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_halt_ctrl.sv
// Bench for fetch_halt_ctrl: behavioural model plus per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_halt_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned TO = 5;
    localparam logic [31:0] HALT_WORD = 32'hFC000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          resume = 1'b0;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          halted;
    logic [AW-1:0] halt_pc;
    logic          timeout_err;
    logic [31:0]   retired;

    fetch_halt_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fetch_halt_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .HALT_OP (6'h3F),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .resume      (resume),
        .imem        (bus),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .halt_pc     (halt_pc),
        .timeout_err (timeout_err),
        .retired     (retired)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int iv_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which mode the controller is in, expressed as flags.
    bit              m_running, m_paused, m_halted;
    int unsigned     m_pc, m_tcnt, m_hpc;
    logic [31:0]     m_instr;
    bit              m_iv, m_terr;
    longint unsigned m_ret;
    logic [31:0]     mem [4];

    task automatic model_step();
        logic [31:0] w;
        w = bus.imem_rdata;
        m_iv = 1'b0;
        if (rst) begin
            m_running = 0; m_paused = 0; m_halted = 0;
            m_pc = 0; m_tcnt = 0; m_hpc = 0; m_instr = '0;
            m_terr = 0; m_ret = 0;
        end else if (m_halted) begin
            if (resume) begin
                m_halted = 0; m_pc = 0; m_terr = 0;
            end
        end else if (m_paused) begin
            if (step || !step_mode) begin
                m_paused = 0; m_running = 1; m_tcnt = 0;
            end
        end else if (m_running) begin
            if (bus.imem_valid) begin
                m_tcnt = 0;
                if (w[31:26] == 6'h3F) begin
                    m_running = 0; m_halted = 1; m_hpc = m_pc;
                end else begin
                    m_instr = w;
                    m_iv    = 1'b1;
                    m_pc    = (m_pc + 1) % (1 << AW);
                    if (m_ret != 64'hFFFF_FFFF) m_ret = m_ret + 1;
                    if (step_mode) begin
                        m_running = 0; m_paused = 1;
                    end
                end
            end else begin
                m_tcnt++;
                if (m_tcnt == TO) begin
                    m_running = 0; m_halted = 1; m_hpc = m_pc; m_terr = 1;
                end
            end
        end else if (start) begin
            m_running = 1; m_tcnt = 0;
        end
    endtask

    // One clock: present memory data, let DUT and model take the edge,
    // return at the following negedge with pulse inputs cleared.
    task automatic tick();
        bus.imem_rdata = bus.imem_valid ? mem[m_pc] : $urandom;
        @(posedge clk);
        model_step();
        @(negedge clk);
        start  = 1'b0;
        step   = 1'b0;
        resume = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",          64'(pc),          64'(m_pc));
            chk("imem_addr",   64'(bus.imem_addr), 64'(m_pc));
            chk("instr",       64'(instr),       64'(m_instr));
            chk("instr_valid", 64'(instr_valid), 64'(m_iv));
            chk("halted",      64'(halted),      64'(m_halted));
            chk("halt_pc",     64'(halt_pc),     64'(m_hpc));
            chk("timeout_err", 64'(timeout_err), 64'(m_terr));
            chk("retired",     64'(retired),     m_ret);
            if (instr_valid === 1'b1) iv_cnt++;
        end
    end

    initial begin
        int exp_seq [6];
        int vpct;
        exp_seq = '{0, 1, 2, 3, 0, 1};
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        mem = '{32'h0, 32'h0, 32'h0, 32'h0};
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Reset values
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);

        // Three words then a halt word at address 3
        mem = '{32'h00000011, 32'h12345678, 32'h0ABCDEF0, HALT_WORD};
        iv_cnt = 0;
        start = 1'b1;
        tick();
        bus.imem_valid = 1'b1;
        repeat (4) tick();
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_pc_lit", 64'(halt_pc), 64'd3);
        chk("halt_retired", 64'(retired), 64'd3);
        chk("halt_iv_pulses", 64'(iv_cnt), 64'd3);
        chk("halt_instr", 64'(instr), 64'h0ABCDEF0);
        start = 1'b1; step = 1'b1;
        repeat (2) tick();
        chk("halt_sticky", 64'(halted), 64'd1);

        // Resume, then start again from address 0
        bus.imem_valid = 1'b0;
        resume = 1'b1;
        tick();
        chk("resume_pc", 64'(pc), 64'd0);
        chk("resume_halted", 64'(halted), 64'd0);
        chk("resume_retired", 64'(retired), 64'd3);
        chk("resume_halt_pc", 64'(halt_pc), 64'd3);
        start = 1'b1;
        tick();
        bus.imem_valid = 1'b1;
        tick();
        chk("restart_instr", 64'(instr), 64'h00000011);
        chk("restart_pc", 64'(pc), 64'd1);
        chk("restart_retired", 64'(retired), 64'd4);

        // Single-step mode
        do_reset();
        mem = '{32'h1, 32'h2, 32'h3, 32'h4};
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        bus.imem_valid = 1'b1;
        tick();
        chk("step_pc1", 64'(pc), 64'd1);
        chk("step_ret1", 64'(retired), 64'd1);
        repeat (2) tick();
        chk("pause_hold_pc", 64'(pc), 64'd1);
        chk("pause_hold_ret", 64'(retired), 64'd1);
        step = 1'b1;
        tick();
        tick();
        chk("step_pc2", 64'(pc), 64'd2);
        chk("step_instr2", 64'(instr), 64'h2);
        chk("step_ret2", 64'(retired), 64'd2);
        step_mode = 1'b0;

        // PC wrap with ADDR_W=2
        do_reset();
        start = 1'b1;
        tick();
        chk("wrap_pc0", 64'(pc), 64'(exp_seq[0]));
        bus.imem_valid = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tick();
            chk("wrap_pc", 64'(pc), 64'(exp_seq[i]));
        end
        chk("wrap_no_halt", 64'(halted), 64'd0);
        chk("wrap_retired", 64'(retired), 64'd5);

        // Fetch timeout
        do_reset();
        start = 1'b1;
        tick();
        repeat (TO - 1) tick();
        chk("to_not_yet", 64'(halted), 64'd0);
        tick();
        chk("to_halted", 64'(halted), 64'd1);
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_halt_pc", 64'(halt_pc), 64'd0);
        resume = 1'b1;
        tick();
        chk("to_err_clr", 64'(timeout_err), 64'd0);

        // Reset arriving together with a halt word
        do_reset();
        mem = '{32'h5, HALT_WORD, 32'h7, 32'h8};
        start = 1'b1;
        tick();
        bus.imem_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_valid = 1'b0;
        chk("rsthalt_halted", 64'(halted), 64'd0);
        chk("rsthalt_halt_pc", 64'(halt_pc), 64'd0);
        chk("rsthalt_retired", 64'(retired), 64'd0);
        chk("rsthalt_pc", 64'(pc), 64'd0);
        chk("rsthalt_instr", 64'(instr), 64'd0);
        tick();
        chk("rsthalt_idle", 64'(halted), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0:       vpct = 75;
                1:       vpct = 20;
                default: vpct = 95;
            endcase
            rst    = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 7) == 0);
            step   = ($urandom_range(0, 3) == 0);
            resume = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
            bus.imem_valid = ($urandom_range(0, 99) < vpct);
            if ($urandom_range(0, 7) == 0) begin
                mem[$urandom_range(0, 3)] = ($urandom_range(0, 5) == 0)
                    ? (HALT_WORD | ($urandom & 32'h03FF_FFFF)) : $urandom;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
